// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction-fetch stage: PC, req/ready fetch, one-entry buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter int                   PC_WIDTH  = 16,
    parameter int                   INS_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = 16'h0000,
    parameter logic [INS_WIDTH-1:0] EMPTY_INS = 16'h0800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_pause,
    input  logic                 branch_valid,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 mem_busy,
    output logic                 ram_req,
    output logic [PC_WIDTH-1:0]  ram_addr,
    input  logic                 ram_ready,
    input  logic [INS_WIDTH-1:0] ram_rdata,
    output logic [INS_WIDTH-1:0] ram_out_ins,
    output logic [PC_WIDTH-1:0]  pc_add_value,
    output logic                 pc_clear
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pc_buf_q, pc_buf_d;
    logic [INS_WIDTH-1:0]   ins_buf_q, ins_buf_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;

    logic                   can_issue;
    logic                   consume;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            pc_buf_q     <= '0;
            ins_buf_q    <= EMPTY_INS;
            buf_valid_q  <= 1'b0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_buf_q     <= pc_buf_d;
            ins_buf_q    <= ins_buf_d;
            buf_valid_q  <= buf_valid_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign can_issue    = ~mem_busy & ~branch_valid & (~buf_valid_q | ~pc_pause);
    assign consume      = buf_valid_q & ~pc_pause;
    assign pc_clear     = ~buf_valid_q;
    assign ram_out_ins  = buf_valid_q ? ins_buf_q : EMPTY_INS;
    assign pc_add_value = pc_buf_q + PC_ONE;

    // Request is gated by reset so an outstanding transfer is dropped at once.
    always_comb begin
        ram_req  = 1'b0;
        ram_addr = pc_q;
        case (state_q)
            S_FETCH: ram_req = rst & can_issue;
            S_WAIT:  ram_req = rst;
            S_DRAIN: begin
                ram_req  = rst;
                ram_addr = drain_addr_q;
            end
            default: ram_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_buf_d     = pc_buf_q;
        ins_buf_d    = ins_buf_q;
        buf_valid_d  = buf_valid_q & ~consume;
        drain_addr_d = drain_addr_q;

        if (branch_valid) begin
            pc_d        = branch_target;
            buf_valid_d = 1'b0;
            case (state_q)
                S_FETCH: state_d = S_FETCH;
                S_WAIT: begin
                    state_d      = ram_ready ? S_FETCH : S_DRAIN;
                    drain_addr_d = pc_q;
                end
                S_DRAIN: state_d = ram_ready ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ram_req && ram_ready) begin
                        ins_buf_d   = ram_rdata;
                        pc_buf_d    = pc_q;
                        buf_valid_d = 1'b1;
                        pc_d        = pc_q + PC_ONE;
                    end else if (ram_req) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ram_ready) begin
                        ins_buf_d   = ram_rdata;
                        pc_buf_d    = pc_q;
                        buf_valid_d = 1'b1;
                        pc_d        = pc_q + PC_ONE;
                        state_d     = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (ram_ready) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Directed self-checking bench for if_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_pause;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        mem_busy;
    logic        ram_req;
    logic [15:0] ram_addr;
    logic        ram_ready;
    logic [15:0] ram_rdata;
    logic [15:0] ram_out_ins;
    logic [15:0] pc_add_value;
    logic        pc_clear;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_pause      (pc_pause),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .mem_busy      (mem_busy),
        .ram_req       (ram_req),
        .ram_addr      (ram_addr),
        .ram_ready     (ram_ready),
        .ram_rdata     (ram_rdata),
        .ram_out_ins   (ram_out_ins),
        .pc_add_value  (pc_add_value),
        .pc_clear      (pc_clear)
    );

    // Memory contents: word at address a is a ^ 16'h5A00.
    assign ram_rdata = ram_addr ^ 16'h5A00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pc_pause = 1'b0; branch_valid = 1'b0; branch_target = 16'h0;
        mem_busy = 1'b0; ram_ready = 1'b1;
        #3;
        check("rst_req",   16'(ram_req), 16'h0000);
        check("rst_clear", 16'(pc_clear), 16'h0001);
        check("rst_ins",   ram_out_ins, 16'h0800);
        check("rst_pcadd", pc_add_value, 16'h0001);

        // Stream with always-ready memory
        tick();
        rst = 1'b1;
        #1;
        check("str_req0",  16'(ram_req), 16'h0001);
        check("str_addr0", ram_addr, 16'h0000);
        tick(); #1;
        check("str_addr1", ram_addr, 16'h0001);
        check("str_pca1",  pc_add_value, 16'h0001);
        check("str_clr1",  16'(pc_clear), 16'h0000);
        check("str_ins1",  ram_out_ins, 16'h5A00);
        tick(); #1;
        check("str_addr2", ram_addr, 16'h0002);
        check("str_pca2",  pc_add_value, 16'h0002);
        tick(); #1;
        check("str_pca3",  pc_add_value, 16'h0003);
        tick(); tick(); #1;
        check("ws_pre_addr", ram_addr, 16'h0005);

        // Wait states at address 5: ready withheld 3 cycles
        for (int i = 1; i <= 4; i++) begin
            ram_ready = (i == 4);
            #1;
            check("ws_addr", ram_addr, 16'h0005);
            check("ws_req",  16'(ram_req), 16'h0001);
            if (i >= 2) check("ws_clear", 16'(pc_clear), 16'h0001);
            tick();
        end
        #1;
        check("ws_pca",   pc_add_value, 16'h0006);
        check("ws_ins",   ram_out_ins, 16'h5A05);
        check("ws_clr",   16'(pc_clear), 16'h0000);
        check("ws_next",  ram_addr, 16'h0006);

        // Stall holding instruction from address 7
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            pc_pause = 1'b1;
            #1;
            check("st_req", 16'(ram_req), 16'h0000);
            check("st_pca", pc_add_value, 16'h0008);
            check("st_ins", ram_out_ins, 16'h5A07);
            check("st_clr", 16'(pc_clear), 16'h0000);
            tick();
        end
        pc_pause = 1'b0;
        #1;
        check("st_rel_req",  16'(ram_req), 16'h0001);
        check("st_rel_addr", ram_addr, 16'h0008);

        // Redirect during WAIT on address 9
        tick();
        ram_ready = 1'b0;
        #1;
        check("br_addr9", ram_addr, 16'h0009);
        tick();
        branch_valid = 1'b1; branch_target = 16'h0040;
        #1;
        check("br_wait_req",  16'(ram_req), 16'h0001);
        check("br_wait_addr", ram_addr, 16'h0009);
        tick();
        branch_valid = 1'b0;
        #1;
        check("br_drain_addr", ram_addr, 16'h0009);
        check("br_drain_req",  16'(ram_req), 16'h0001);
        check("br_drain_clr",  16'(pc_clear), 16'h0001);
        tick(); #1;
        check("br_drain_addr2", ram_addr, 16'h0009);
        ram_ready = 1'b1;
        tick(); #1;
        check("br_drop_clr", 16'(pc_clear), 16'h0001);
        check("br_new_addr", ram_addr, 16'h0040);
        check("br_new_req",  16'(ram_req), 16'h0001);
        tick(); #1;
        check("br_pca", pc_add_value, 16'h0041);
        check("br_ins", ram_out_ins, 16'h5A40);

        // Structural conflict then wrap
        for (int i = 0; i < 2; i++) begin
            mem_busy = 1'b1;
            #1;
            check("mb_req", 16'(ram_req), 16'h0000);
            tick();
        end
        mem_busy = 1'b0;
        branch_valid = 1'b1; branch_target = 16'hFFFF;
        #1;
        check("wr_br_req", 16'(ram_req), 16'h0000);
        tick();
        branch_valid = 1'b0;
        #1;
        check("wr_addr", ram_addr, 16'hFFFF);
        check("wr_req",  16'(ram_req), 16'h0001);
        tick(); #1;
        check("wr_pca",  pc_add_value, 16'h0000);
        check("wr_ins",  ram_out_ins, 16'hA5FF);
        check("wr_next", ram_addr, 16'h0000);

        // Reset mid-WAIT
        ram_ready = 1'b0;
        tick(); #1;
        check("rw_req", 16'(ram_req), 16'h0001);
        rst = 1'b0;
        #1;
        check("rw_drop", 16'(ram_req), 16'h0000);
        check("rw_clr",  16'(pc_clear), 16'h0001);
        tick();
        rst = 1'b1; ram_ready = 1'b1;
        #1;
        check("rw_restart_addr", ram_addr, 16'h0000);
        check("rw_restart_req",  16'(ram_req), 16'h0001);
        tick(); #1;
        check("rw_pca", pc_add_value, 16'h0001);
        check("rw_ins", ram_out_ins, 16'h5A00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
